// File: rtl/ttl_74157_scanner.sv
`default_nettype none
// ============================================================================
// Module      : ttl_74157_scanner
// Description : Scan sequencer for a quad 2-input mux. It steps Select through
//               every channel, captures Y into a shadow frame and publishes it
//               atomically on Q_2D.
// Revision    : 1.0 - initial release
// ============================================================================
module ttl_74157_scanner #(
    parameter int BLOCKS       = 4,
    parameter int WIDTH_IN     = 2,
    parameter int WIDTH_SELECT = $clog2(WIDTH_IN),
    parameter int DWELL        = 2,
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic                         Clk,
    input  logic                         Clear_bar,
    input  logic                         Start,
    input  logic                         Continuous,
    input  logic [BLOCKS-1:0]            Y_in,
    output logic [WIDTH_SELECT-1:0]      Select,
    output logic                         Enable_bar,
    output logic [BLOCKS*WIDTH_IN-1:0]   Q_2D,
    output logic                         Busy,
    output logic                         Frame_done
);

    localparam int c_cnt_w = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_cnt_w-1:0]      c_cnt_last = c_cnt_w'(DWELL - 1);
    localparam logic [WIDTH_SELECT-1:0] c_sel_last = WIDTH_SELECT'(WIDTH_IN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                        r_state;
    logic [c_cnt_w-1:0]            r_count;
    logic [WIDTH_SELECT-1:0]       r_select;
    logic                          r_enable_bar;
    logic                          r_busy;
    logic                          r_frame_done;
    logic [BLOCKS*WIDTH_IN-1:0]    r_shadow;
    logic [BLOCKS*WIDTH_IN-1:0]    r_q;
    logic [BLOCKS*WIDTH_IN-1:0]    w_merged;

    // Shadow frame with the channel currently on Select replaced by Y_in, so the
    // final capture and the publish happen on the same edge.
    always_comb begin
        w_merged = r_shadow;
        for (int c = 0; c < WIDTH_IN; c++) begin
            if (r_select == WIDTH_SELECT'(c)) begin
                w_merged[c*BLOCKS +: BLOCKS] = Y_in;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_select     <= '0;
            r_enable_bar <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_shadow     <= '0;
            r_q          <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_enable_bar <= 1'b1;
                    r_busy       <= 1'b0;
                    r_select     <= '0;
                    r_count      <= '0;
                    if (Start) begin
                        r_state      <= ST_SCAN;
                        r_enable_bar <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (r_count != c_cnt_last) begin
                        r_count <= r_count + c_cnt_w'(1);
                    end else begin
                        r_count  <= '0;
                        r_shadow <= w_merged;
                        if (r_select != c_sel_last) begin
                            r_select <= r_select + WIDTH_SELECT'(1);
                        end else begin
                            r_q          <= w_merged;
                            r_frame_done <= 1'b1;
                            r_select     <= '0;
                            if (!Continuous) begin
                                r_state      <= ST_IDLE;
                                r_enable_bar <= 1'b1;
                                r_busy       <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Rise/fall delays are a board-level timing annotation; the registered
    // outputs themselves are driven cycle-accurately.
    if (DELAY_RISE >= 0 && DELAY_FALL >= 0) begin : g_out
        assign Select     = r_select;
        assign Enable_bar = r_enable_bar;
        assign Q_2D       = r_q;
        assign Busy       = r_busy;
        assign Frame_done = r_frame_done;
    end

endmodule
`default_nettype wire
